pkt_rr_mux: RTL

//  - N-input, packet-locked, round-robin flit multiplexer for the router datapath.
//  - Generalises the fixed 2:1 select-driven mux:
//    - arbitrates among N ports on HEAD flits and holds the grant until TAIL;
//    - registers the output and applies ready/valid backpressure per input.
//  - Sits between input VC buffers and the output link of one router port.

---
 rtl/pkt_rr_mux_pkg.sv | 25 ++
 rtl/pkt_rr_mux_rr_arbiter.sv | 29 ++
 rtl/pkt_rr_mux.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pkt_rr_mux_pkg.sv
// Shared definitions for pkt_rr_mux: flit type codes, width defaults,
// level constants and the arbitration FSM state type.
package pkt_rr_mux_pkg;

  // Flit type codes; the type field sits in the MSBs of every flit.
  typedef enum logic [1:0] {
    TYPE_NONE = 2'b00,
    TYPE_HEAD = 2'b01,
    TYPE_DATA = 2'b10,
    TYPE_TAIL = 2'b11
  } flit_type_e;

  localparam int DATAW_DEF = 64;
  localparam int VCHW_DEF  = 2;

  localparam logic HIGH   = 1'b1;
  localparam logic ENABLE = 1'b1;

  // IDLE: arbitrating on HEAD flits. LOCKED: one port owns the output.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/pkt_rr_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Grants the first requester
// found at or after ptr, wrapping modulo NPORT. gnt is one-hot or zero.
module rr_arbiter #(
  parameter int NPORT = 2,
  parameter int PW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NPORT-1:0] gnt
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan from ptr upwards and keep only the first hit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NPORT; i++) begin
      idx = PW'((int'(ptr) + i) % NPORT);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_mux.sv
// pkt_rr_mux: N-input packet-locked round-robin flit multiplexer with a
// registered output slot and per-input ready/valid backpressure.
// A port wins on a HEAD flit and keeps the output until its TAIL is taken.
// Optional feature macro TOGGLE_CNT_EN adds the tgl_cnt output, a saturating
// count of bit toggles on odata across output loads.
module pkt_rr_mux
  import pkt_rr_mux_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int DATAW = DATAW_DEF,
  parameter int TYPEW = 2,
  parameter int VCHW  = VCHW_DEF
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic [NPORT*(TYPEW+DATAW)-1:0] idata,
  input  logic [NPORT-1:0]               ivalid,
  input  logic [NPORT*VCHW-1:0]          ivch,
  output logic [NPORT-1:0]               iready,
  output logic [TYPEW+DATAW-1:0]         odata,
  output logic                           ovalid,
  output logic [VCHW-1:0]                ovch,
  input  logic                           oready,
  output logic [NPORT-1:0]               grant,
  output logic                           proto_err
`ifdef TOGGLE_CNT_EN
  ,
  output logic [31:0]                    tgl_cnt
`endif
);

  localparam int FW = TYPEW + DATAW;
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(TYPE_HEAD);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(TYPE_TAIL);

  state_e          state_q, state_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [FW-1:0]   odata_q, odata_d;
  logic [VCHW-1:0] ovch_q, ovch_d;
  logic            ovalid_q, ovalid_d;
  logic            proto_err_q, proto_err_d;

  logic [FW-1:0]    flit_w [NPORT];
  logic [VCHW-1:0]  vch_w  [NPORT];
  logic [NPORT-1:0] head_req, nonhead_req, tail_w;
  logic [NPORT-1:0] pick, ready_w, acc;
  logic [PW-1:0]    owner;
  logic             free, accept;
  logic [FW-1:0]    sel_flit;
  logic [VCHW-1:0]  sel_vch;

  // Per-port slicing and flit-type decode.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign flit_w[gi]      = idata[gi*FW +: FW];
    assign vch_w[gi]       = ivch[gi*VCHW +: VCHW];
    assign head_req[gi]    = ivalid[gi] && (flit_w[gi][FW-1 -: TYPEW] == T_HEAD);
    assign nonhead_req[gi] = ivalid[gi] && (flit_w[gi][FW-1 -: TYPEW] != T_HEAD);
    assign tail_w[gi]      = (flit_w[gi][FW-1 -: TYPEW] == T_TAIL);
  end

  rr_arbiter #(.NPORT(NPORT), .PW(PW)) u_arb (
    .req (head_req),
    .ptr (rr_ptr_q),
    .gnt (pick)
  );

  // Arbitration FSM: ready generation, grant lock/release, rr pointer, error flag.
  always_comb begin
    free        = !ovalid_q || oready;
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = proto_err_q;
    ready_w     = '0;
    owner       = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (grant_q[k]) owner = PW'(k);
    end
    case (state_q)
      ST_IDLE: begin
        ready_w = pick & {NPORT{free}};
        if (|nonhead_req) proto_err_d = ENABLE;
      end
      ST_LOCKED: ready_w = grant_q & {NPORT{free}};
      default: ready_w = '0;
    endcase
    // Nothing is taken while reset is held.
    if (!rst_) ready_w = '0;
    acc    = ivalid & ready_w;
    accept = |acc;
    if (state_q == ST_IDLE && accept) begin
      state_d = ST_LOCKED;
      grant_d = pick;
    end
    if (state_q == ST_LOCKED && |(acc & tail_w)) begin
      state_d  = ST_IDLE;
      grant_d  = '0;
      rr_ptr_d = (owner == PW'(NPORT-1)) ? '0 : owner + 1'b1;
    end
  end

  // Output slot: load the accepted flit, otherwise drain when downstream is ready.
  always_comb begin
    sel_flit = '0;
    sel_vch  = '0;
    for (int k = 0; k < NPORT; k++) begin
      sel_flit = sel_flit | ({FW{acc[k]}} & flit_w[k]);
      sel_vch  = sel_vch  | ({VCHW{acc[k]}} & vch_w[k]);
    end
    odata_d  = odata_q;
    ovch_d   = ovch_q;
    ovalid_d = ovalid_q;
    if (accept) begin
      odata_d  = sel_flit;
      ovch_d   = sel_vch;
      ovalid_d = HIGH;
    end else if (oready) begin
      ovalid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      odata_q     <= '0;
      ovch_q      <= '0;
      ovalid_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      odata_q     <= odata_d;
      ovch_q      <= ovch_d;
      ovalid_q    <= ovalid_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef TOGGLE_CNT_EN
  logic [31:0] tgl_cnt_q, tgl_cnt_d;
  logic [31:0] pc;
  logic [FW-1:0] diff;
  logic [32:0] sum;

  // Toggle counter: popcount of changed odata bits per load, saturating.
  always_comb begin
    diff = odata_q ^ odata_d;
    pc   = '0;
    for (int i = 0; i < FW; i++) begin
      pc = pc + 32'(diff[i]);
    end
    sum       = {1'b0, tgl_cnt_q} + {1'b0, pc};
    tgl_cnt_d = tgl_cnt_q;
    if (accept) tgl_cnt_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  end

  // Toggle counter register.
  always_ff @(posedge clk) begin
    if (!rst_) tgl_cnt_q <= '0;
    else       tgl_cnt_q <= tgl_cnt_d;
  end

  assign tgl_cnt = tgl_cnt_q;
`endif

  assign iready    = ready_w;
  assign odata     = odata_q;
  assign ovalid    = ovalid_q;
  assign ovch      = ovch_q;
  assign grant     = grant_q;
  assign proto_err = proto_err_q;

endmodule
